mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns an EX/MEM load/store into a single bus transaction,
// stalls the pipeline while it is outstanding and returns the extended load data.
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_mem_out,
  output logic        mem_stall,
  output logic        mem_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_access;
  logic        w_misaligned;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_load;

  // Picks the addressed lane of the bus word and widens it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   extend_load = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   extend_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: extend_load = rdata;
    endcase
  endfunction

  assign w_access     = mem_read | mem_write;
  assign mem_misalign = w_access & w_misaligned;
  assign w_start      = w_access & ~w_misaligned;
  assign w_load       = extend_load(dmem_rdata, r_lane, r_size, r_unsigned);

  // Alignment check plus store lane steering, both decoded from the access size.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = mem_store_data;
    case (mem_size)
      2'b00: begin
        w_misaligned = 1'b0;
        w_be         = 4'b0001 << mem_alu_out[1:0];
        w_wdata      = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        w_misaligned = mem_alu_out[0];
        w_be         = 4'b0011 << mem_alu_out[1:0];
        w_wdata      = {2{mem_store_data[15:0]}};
      end
      default: begin
        w_misaligned = (mem_alu_out[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = mem_store_data;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and stall; DONE releases the pipeline for exactly one cycle.
  always_comb begin
    w_next    = r_state;
    mem_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next    = REQ;
          mem_stall = 1'b1;
        end else begin
          w_next    = IDLE;
          mem_stall = 1'b0;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_ready) w_next = DONE;
        else            w_next = REQ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs and load result; lane/size are captured so the return path
  // does not depend on the frozen EX/MEM contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0000_0000;
      dmem_wdata  <= 32'h0000_0000;
      dmem_be     <= 4'b0000;
      mem_mem_out <= 32'h0000_0000;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {mem_alu_out[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_lane     <= mem_alu_out[1:0];
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_load     <= ~mem_write;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (r_load) mem_mem_out <= w_load;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1 ns after each rising edge,
// outputs are sampled 1-2 ns after the edge.
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_mem_out;
  logic        mem_stall;
  logic        mem_misalign;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;

  mem_stage dut (
    .clock(clock), .reset(reset),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_mem_out(mem_mem_out), .mem_stall(mem_stall), .mem_misalign(mem_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] data);
    mem_read       = rd;
    mem_write      = wr;
    mem_alu_out    = addr;
    mem_size       = size;
    mem_unsigned   = uns;
    mem_store_data = data;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000);
  endtask

  initial begin
    reset = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'h0000_0000;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    check("rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_we",    {31'd0, dmem_we}, 32'd0);
    check("rst_addr",  dmem_addr, 32'h0000_0000);
    check("rst_wdata", dmem_wdata, 32'h0000_0000);
    check("rst_be",    {28'd0, dmem_be}, 32'd0);
    check("rst_out",   mem_mem_out, 32'h0000_0000);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_mis",   {31'd0, mem_misalign}, 32'd0);

    // Word load at 0x100, ready in the first REQ cycle
    tick();
    drive(1'b1, 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0000_0000);
    #1;
    check("wl_stall_idle", {31'd0, mem_stall}, 32'd1);
    check("wl_mis", {31'd0, mem_misalign}, 32'd0);
    tick();
    check("wl_req",  {31'd0, dmem_req}, 32'd1);
    check("wl_addr", dmem_addr, 32'h0000_0100);
    check("wl_be",   {28'd0, dmem_be}, 32'h0000_000F);
    check("wl_we",   {31'd0, dmem_we}, 32'd0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("wl_stall_req", {31'd0, mem_stall}, 32'd1);
    tick();
    dmem_ready = 1'b0;
    check("wl_out",        mem_mem_out, 32'hDEAD_BEEF);
    check("wl_req_done",   {31'd0, dmem_req}, 32'd0);
    check("wl_stall_done", {31'd0, mem_stall}, 32'd0);
    idle_inputs();

    // Signed byte load at 0x103
    tick();
    drive(1'b1, 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0000_0000);
    tick();
    check("sb_addr", dmem_addr, 32'h0000_0100);
    check("sb_be",   {28'd0, dmem_be}, 32'h0000_0008);
    dmem_ready = 1'b1; dmem_rdata = 32'h80AA_BBCC;
    tick();
    dmem_ready = 1'b0;
    check("sb_out", mem_mem_out, 32'hFFFF_FF80);
    idle_inputs();

    // Unsigned byte load at 0x103
    tick();
    drive(1'b1, 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0000_0000);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h80AA_BBCC;
    tick();
    dmem_ready = 1'b0;
    check("ub_out", mem_mem_out, 32'h0000_0080);
    idle_inputs();

    // Half store at 0x202; bus returns junk which must not reach mem_mem_out
    tick();
    drive(1'b0, 1'b1, 32'h0000_0202, 2'b01, 1'b0, 32'h1234_ABCD);
    #1;
    check("hs_mis", {31'd0, mem_misalign}, 32'd0);
    tick();
    check("hs_addr",  dmem_addr, 32'h0000_0200);
    check("hs_be",    {28'd0, dmem_be}, 32'h0000_000C);
    check("hs_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("hs_we",    {31'd0, dmem_we}, 32'd1);
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ready = 1'b0;
    check("hs_out", mem_mem_out, 32'h0000_0080);
    idle_inputs();

    // Misaligned word load at 0x101
    tick();
    drive(1'b1, 1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0000_0000);
    #1;
    check("ma_mis",   {31'd0, mem_misalign}, 32'd1);
    check("ma_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("ma_req",  {31'd0, dmem_req}, 32'd0);
    check("ma_out",  mem_mem_out, 32'h0000_0080);
    // Misaligned half, and an unaligned address with no access
    drive(1'b0, 1'b1, 32'h0000_0205, 2'b01, 1'b0, 32'h0000_0000);
    #1;
    check("mh_mis", {31'd0, mem_misalign}, 32'd1);
    tick();
    check("mh_req", {31'd0, dmem_req}, 32'd0);
    drive(1'b0, 1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0000_0000);
    #1;
    check("na_mis", {31'd0, mem_misalign}, 32'd0);

    // dmem_ready while idle is ignored
    dmem_ready = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_ready = 1'b0;
    check("ign_out", mem_mem_out, 32'h0000_0080);
    check("ign_req", {31'd0, dmem_req}, 32'd0);

    // Word load at 0x300, ready on the 5th REQ cycle
    drive(1'b1, 1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'h0000_0000);
    stall_cnt = 0;
    #1;
    if (mem_stall) stall_cnt++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("dl_req",   {31'd0, dmem_req}, 32'd1);
      check("dl_addr",  dmem_addr, 32'h0000_0300);
      check("dl_be",    {28'd0, dmem_be}, 32'h0000_000F);
      check("dl_we",    {31'd0, dmem_we}, 32'd0);
      if (k == 5) begin
        dmem_ready = 1'b1; dmem_rdata = 32'h1122_3344;
      end
      #1;
      if (mem_stall) stall_cnt++;
    end
    tick();
    dmem_ready = 1'b0;
    if (mem_stall) stall_cnt++;
    check("dl_out", mem_mem_out, 32'h1122_3344);
    idle_inputs();
    tick();
    if (mem_stall) stall_cnt++;
    check("dl_req_after", {31'd0, dmem_req}, 32'd0);
    check("dl_stall_cnt", stall_cnt, 32'd6);

    // Reset during REQ, then a stray dmem_ready
    drive(1'b1, 1'b0, 32'h0000_0400, 2'b10, 1'b0, 32'h0000_0000);
    tick();
    check("rr_req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    check("rr_req", {31'd0, dmem_req}, 32'd0);
    check("rr_out", mem_mem_out, 32'h0000_0000);
    check("rr_stall", {31'd0, mem_stall}, 32'd0);
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ready = 1'b0;
    check("rr_ign_out", mem_mem_out, 32'h0000_0000);
    // A new access starting immediately shows the FSM is back in IDLE
    drive(1'b1, 1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0000_0000);
    #1;
    check("rr_idle_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    check("rr_new_req",  {31'd0, dmem_req}, 32'd1);
    check("rr_new_addr", dmem_addr, 32'h0000_0500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
